// File: rtl/lfsr_pkg.sv
// Shared constants for the LFSR generator: legal width range and the
// maximal-length tap masks (bit n-1 set for each x^n term).
package lfsr_pkg;

    localparam int LFSR_MIN_WIDTH = 3;
    localparam int LFSR_MAX_WIDTH = 16;

    localparam logic [15:0] TAPS [LFSR_MIN_WIDTH:LFSR_MAX_WIDTH] = '{
        16'h0006,   // 3 : x^3+x^2+1
        16'h000C,   // 4 : x^4+x^3+1
        16'h0014,   // 5 : x^5+x^3+1
        16'h0030,   // 6 : x^6+x^5+1
        16'h0060,   // 7 : x^7+x^6+1
        16'h00B8,   // 8 : x^8+x^6+x^5+x^4+1
        16'h0110,   // 9 : x^9+x^5+1
        16'h0240,   // 10: x^10+x^7+1
        16'h0500,   // 11: x^11+x^9+1
        16'h0829,   // 12: x^12+x^6+x^4+x+1
        16'h100D,   // 13: x^13+x^4+x^3+x+1
        16'h2015,   // 14: x^14+x^5+x^3+x+1
        16'h6000,   // 15: x^15+x^14+1
        16'hD008    // 16: x^16+x^15+x^13+x^4+1
    };

endpackage

// File: rtl/lfsr_period_chk.sv
// Period checker for lfsr_gen: flags a zero state reached off the terminal
// count, or a missed zero at the terminal count, while armed.
module lfsr_period_chk
    import lfsr_pkg::*;
#(
    parameter int WIDTH = 8
)
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_seed,
    input  logic             i_adv,
    input  logic [WIDTH-1:0] i_next,
    input  logic [WIDTH-1:0] i_count,
    output logic             o_err
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic r_armed;
    logic r_err;
    logic w_fault;

    // Only a zero seed keeps count aligned with the position in the cycle.
    assign w_fault = (i_next == '0) ? (i_count != CNT_MAX) : (i_count == CNT_MAX);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_armed <= 1'b1;
            r_err   <= 1'b0;
        end else if (i_load) begin
            r_armed <= (i_seed == '0);
        end else if (i_adv && r_armed && w_fault) begin
            r_err   <= 1'b1;
        end
    end

    assign o_err = r_err;

endmodule

// File: rtl/lfsr_gen.sv
// Full-period (2^WIDTH, zero included) Fibonacci LFSR with step counter and wrap pulse.
// Optional period checker enabled by defining LFSR_GEN_PERIOD_CHECK_EN.
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int WIDTH = 8
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             err
);

    if (WIDTH < LFSR_MIN_WIDTH || WIDTH > LFSR_MAX_WIDTH) begin : g_width_bad
        $error("lfsr_gen: WIDTH %0d outside %0d..%0d", WIDTH, LFSR_MIN_WIDTH, LFSR_MAX_WIDTH);
    end

    localparam logic [WIDTH-1:0] TAP_MASK = TAPS[WIDTH][WIDTH-1:0];

    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic             w_fb;
    logic [WIDTH-1:0] w_next;

    // Extra XOR on an all-zero low field splices state 0 into the m-sequence.
    assign w_fb   = (^(r_state & TAP_MASK)) ^ (r_state[WIDTH-2:0] == '0);
    assign w_next = {r_state[WIDTH-2:0], w_fb};

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= '0;
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else if (load) begin
            r_state <= seed;
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else if (en) begin
            r_state <= w_next;
            r_count <= r_count + 1'b1;
            r_wrap  <= (w_next == '0);
        end else begin
            r_wrap  <= 1'b0;
        end
    end

    assign out   = r_state;
    assign count = r_count;
    assign wrap  = r_wrap;

`ifdef LFSR_GEN_PERIOD_CHECK_EN
    logic w_adv;

    assign w_adv = en & ~load;

    lfsr_period_chk #(.WIDTH(WIDTH)) u_period_chk (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_load  (load),
        .i_seed  (seed),
        .i_adv   (w_adv),
        .i_next  (w_next),
        .i_count (r_count),
        .o_err   (err)
    );
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_gen.sv
// Scoreboard bench for lfsr_gen: randomized stimulus against a cycle-position
// reference model, plus a free-running period sweep over WIDTH 3..16.
module tb_lfsr_gen;

`ifdef LFSR_GEN_PERIOD_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct {
        int out;
        int cnt;
        int wrap;
        int err;
        int fix;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=8 main DUT
    logic       rst8, en8, load8, wrap8, err8;
    logic [7:0] seed8, out8, cnt8;
    lfsr_gen #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst8), .en(en8), .load(load8), .seed(seed8),
        .out(out8), .count(cnt8), .wrap(wrap8), .err(err8)
    );

    // WIDTH=4 DUT for the load/en priority case
    logic       rst4, en4, load4, wrap4, err4;
    logic [3:0] seed4, out4, cnt4;
    lfsr_gen #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst4), .en(en4), .load(load4), .seed(seed4),
        .out(out4), .count(cnt4), .wrap(wrap4), .err(err4)
    );

    // Period sweep instances, one per legal width
    logic sw_rst = 1'b0, sw_en = 1'b0, sw_run = 1'b0;
    wire [31:0] sw_distinct [3:16];
    wire [31:0] sw_first0   [3:16];
    wire [31:0] sw_bad      [3:16];

    for (genvar g = 3; g <= 16; g++) begin : g_sw
        localparam int N = 1 << g;
        logic [g-1:0] w_out, w_cnt;
        logic         w_wrap, w_err;
        bit           seen [N];
        int           k = 0, n_distinct = 0, first0 = 0, n_bad = 0;

        lfsr_gen #(.WIDTH(g)) u_sw (
            .clk(clk), .rst(sw_rst), .en(sw_en), .load(1'b0), .seed({g{1'b0}}),
            .out(w_out), .count(w_cnt), .wrap(w_wrap), .err(w_err)
        );

        always @(negedge clk) begin
            if (sw_run) begin
                if (k < N && !seen[w_out]) begin
                    seen[w_out] = 1'b1;
                    n_distinct++;
                end
                if (k > 0 && k <= N && w_out == '0 && first0 == 0) first0 = k;
                if (k <= N && (int'(w_cnt) != (k % N) || w_wrap != (k == N) || w_err))
                    n_bad++;
                k++;
            end
        end

        assign sw_distinct[g] = n_distinct;
        assign sw_first0[g]   = first0;
        assign sw_bad[g]      = n_bad;
    end

    // Reference model: the full cycle order from 0, then track position in it
    int ord8 [256], pos8 [256], ord4 [16], pos4 [16];
    int m8_pos, m8_cnt, m8_err, m4_pos, m4_cnt;
    bit m8_armed;
    exp_t q8 [$], q4 [$];
    int fix028 [5] = '{1, 2, 4, 8, 17};

    int  n_pass = 0, n_total = 0;
    bit  do_sweep_chk = 1'b0, sweep_done = 1'b0;

    function automatic int lfsr_next(int w, int taps, int s);
        int n  = 1 << w;
        int fb = 0;
        for (int b = 0; b < w; b++)
            if ((((taps >> b) & 1) == 1) && (((s >> b) & 1) == 1)) fb ^= 1;
        if (s % (n / 2) == 0) fb ^= 1;
        return (s * 2 + fb) % n;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic cyc8(input bit r, input bit l, input bit e, input int sd, input int fix);
        exp_t x;
        int   s = sd & 255;
        rst8 = r; load8 = l; en8 = e; seed8 = s[7:0];
        @(posedge clk);
        x.wrap = 0;
        if (!r) begin
            m8_pos = 0; m8_cnt = 0; m8_err = 0; m8_armed = 1'b1;
        end else if (l) begin
            m8_pos = pos8[s]; m8_cnt = 0; m8_armed = (s == 0);
        end else if (e) begin
            int nxt = ord8[(m8_pos + 1) % 256];
            if (CHK && m8_armed && ((nxt == 0) != (m8_cnt == 255))) m8_err = 1;
            m8_pos = (m8_pos + 1) % 256;
            m8_cnt = (m8_cnt + 1) % 256;
            x.wrap = (nxt == 0);
        end
        x.out = ord8[m8_pos]; x.cnt = m8_cnt; x.err = m8_err; x.fix = fix;
        q8.push_back(x);
        #1;
    endtask

    task automatic cyc4(input bit r, input bit l, input bit e, input int sd);
        exp_t x;
        int   s = sd & 15;
        rst4 = r; load4 = l; en4 = e; seed4 = s[3:0];
        @(posedge clk);
        x.wrap = 0;
        if (!r) begin
            m4_pos = 0; m4_cnt = 0;
        end else if (l) begin
            m4_pos = pos4[s]; m4_cnt = 0;
        end else if (e) begin
            m4_pos = (m4_pos + 1) % 16;
            m4_cnt = (m4_cnt + 1) % 16;
            x.wrap = (ord4[m4_pos] == 0);
        end
        x.out = ord4[m4_pos]; x.cnt = m4_cnt; x.err = 0; x.fix = -1;
        q4.push_back(x);
        #1;
    endtask

    // Monitor: every comparison happens here
    always @(negedge clk) begin
        exp_t e;
        if (q8.size() != 0) begin
            e = q8.pop_front();
            check("out8",   int'(out8),  e.out);
            check("count8", int'(cnt8),  e.cnt);
            check("wrap8",  int'(wrap8), e.wrap);
            check("err8",   int'(err8),  e.err);
            if (e.fix >= 0) check("seq_after_reset", int'(out8), e.fix);
        end
        if (q4.size() != 0) begin
            e = q4.pop_front();
            check("out4",   int'(out4),  e.out);
            check("count4", int'(cnt4),  e.cnt);
            check("wrap4",  int'(wrap4), e.wrap);
            check("err4",   int'(err4),  e.err);
        end
        if (do_sweep_chk && !sweep_done) begin
            for (int i = 3; i <= 16; i++) begin
                check($sformatf("sweep_distinct_w%0d", i), int'(sw_distinct[i]), 1 << i);
                check($sformatf("sweep_first_zero_w%0d", i), int'(sw_first0[i]), 1 << i);
                check($sformatf("sweep_cnt_wrap_err_w%0d", i), int'(sw_bad[i]), 0);
            end
            sweep_done = 1'b1;
        end
    end

    initial begin
        int s;
        s = 0;
        for (int i = 0; i < 256; i++) begin ord8[i] = s; pos8[s] = i; s = lfsr_next(8, 'hB8, s); end
        s = 0;
        for (int i = 0; i < 16; i++) begin ord4[i] = s; pos4[s] = i; s = lfsr_next(4, 'hC, s); end
        m8_pos = 0; m8_cnt = 0; m8_err = 0; m8_armed = 1'b1; m4_pos = 0; m4_cnt = 0;
        rst8 = 1'b0; en8 = 1'b0; load8 = 1'b0; seed8 = '0;
        rst4 = 1'b0; en4 = 1'b0; load4 = 1'b0; seed4 = '0;
        @(negedge clk);

        // Reset state, reset overriding load/en
        cyc8(0, 0, 0, 0, -1);
        cyc8(0, 1, 1, 'h55, -1);
        // Full period from reset; first steps against the documented sequence
        for (int i = 0; i < 256; i++) cyc8(1, 0, 1, 0, (i < 5) ? fix028[i] : -1);
        for (int i = 0; i < 3; i++) cyc8(1, 0, 0, 0, -1);
        // Reset mid-sequence restarts at 0, next advance gives 0x01
        for (int i = 0; i < 100; i++) cyc8(1, 0, 1, 0, -1);
        cyc8(0, 1, 1, 'h3C, -1);
        cyc8(1, 0, 1, 0, 1);
        // Load of 0 does not pulse wrap; nonzero seed load disarms the checker
        cyc8(1, 1, 0, 0, -1);
        cyc8(1, 0, 0, 0, -1);
        cyc8(1, 1, 0, 'h80, -1);
        cyc8(1, 0, 1, 0, -1);
        cyc8(1, 0, 1, 0, -1);
        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            bit r = ($urandom_range(0, 39) != 0);
            bit l = ($urandom_range(0, 7) == 0);
            bit e = ($urandom_range(0, 1) == 1);
            int sd = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(0, 255));
            cyc8(r, l, e, sd, -1);
        end

`ifdef LFSR_GEN_PERIOD_CHECK_EN
        // Armed checker: jam the state to the predecessor of 0 at count 50
        cyc8(0, 0, 0, 0, -1);
        cyc8(1, 1, 0, 0, -1);
        for (int i = 0; i < 50; i++) cyc8(1, 0, 1, 0, -1);
        @(negedge clk);
        #1;
        force dut.r_state = 8'h80;
        #1;
        release dut.r_state;
        m8_pos = pos8[8'h80];
        cyc8(1, 0, 1, 0, -1);
        for (int i = 0; i < 3; i++) cyc8(1, 0, 1, 0, -1);
        cyc8(1, 1, 0, 'h33, -1);
        cyc8(1, 0, 1, 0, -1);
`endif
        cyc8(0, 0, 0, 0, -1);
        cyc8(1, 0, 0, 0, -1);
        rst8 = 1'b1; en8 = 1'b0; load8 = 1'b0;

        // WIDTH=4: load wins over en, then advances only on en=1 cycles
        cyc4(0, 0, 0, 0);
        cyc4(1, 1, 1, 9);
        cyc4(1, 0, 1, 0);
        cyc4(1, 0, 0, 0);
        cyc4(1, 0, 1, 0);
        cyc4(1, 0, 0, 0);
        cyc4(1, 0, 1, 0);
        cyc4(1, 0, 1, 0);
        for (int i = 0; i < 16; i++) cyc4(1, 0, 1, 0);
        rst4 = 1'b1; en4 = 1'b0; load4 = 1'b0;

        // Period sweep: release reset with en=1 and run past 2^16 steps
        @(posedge clk);
        #1;
        sw_rst = 1'b1;
        sw_en  = 1'b1;
        sw_run = 1'b1;
        repeat (65540) @(negedge clk);
        #1;
        sw_run = 1'b0;
        sw_en  = 1'b0;

        for (int t = 0; t < 10 && (q8.size() != 0 || q4.size() != 0); t++) @(negedge clk);
        if (q8.size() != 0 || q4.size() != 0) begin
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", q8.size() + q4.size());
            $fatal(1, "scoreboard did not drain");
        end
        do_sweep_chk = 1'b1;
        for (int t = 0; t < 10 && !sweep_done; t++) @(negedge clk);
        if (!sweep_done) begin
            $display("FAIL sweep_check_timeout: got 0 expected 1");
            $fatal(1, "sweep check never ran");
        end
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/lfsr_gen.md
LFSR_GEN -- requirements
Module: lfsr_gen

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 8, meaning register width in bits, legal range 3..16.
REQ-002 The block SHALL expose port clk  input  1  the single rising-edge clock.
REQ-003 The block SHALL expose port rst  input  1  reset, synchronous, active-low.
REQ-004 The block SHALL expose port en  input  1  high advances the sequence one step.
REQ-005 The block SHALL expose port load  input  1  high loads seed into the state.
REQ-006 The block SHALL expose port seed  input  WIDTH  the value written by load.
REQ-007 The block SHALL expose port out  output  WIDTH  current state, driven straight from the state register.
REQ-008 The block SHALL expose port count  output  WIDTH  number of steps since the last reset or load, modulo 2^WIDTH.
REQ-009 The block SHALL expose port wrap  output  1  one-cycle pulse when an advance returns the state to zero.
REQ-010 The block SHALL expose port err  output  1  sticky period-check failure flag.

Function
REQ-011 The state SHALL be a Fibonacci LFSR: on each advance the state shifts left by one and bit0 takes fb.
REQ-012 fb SHALL be the XOR of state bits selected by TAPS[WIDTH], XORed with 1 when state[WIDTH-2:0]==0.
REQ-013 The sequence SHALL therefore visit all 2^WIDTH values, zero included, with period exactly 2^WIDTH.
REQ-014 An advance SHALL occur on a clock edge where en=1 and load=0.
REQ-015 load=1 SHALL take priority over en: state<=seed, count<=0, wrap<=0.
REQ-016 With en=0 and load=0, state and count SHALL hold and wrap SHALL be 0.
REQ-017 count SHALL increment on every advance and wrap from 2^WIDTH-1 to 0.
REQ-018 wrap SHALL be registered and high only in the cycle after an advance whose next state is 0; it SHALL stay low when a load or reset produces 0.
REQ-019 out and count SHALL update one cycle after the qualifying edge; the block SHALL have no other latency.

Reset
REQ-020 When rst=0 at a rising clk edge, the block SHALL set state=0, count=0, wrap=0 and err=0, overriding load and en.
REQ-021 Reset asserted mid-sequence SHALL restart the sequence at 0, with the next advance giving 0x01.

Configuration
REQ-022 When LFSR_GEN_PERIOD_CHECK_EN is defined, the block SHALL contain a period checker. The checker SHALL be armed by reset and by a load of seed==0, and disarmed by a load of any nonzero seed. While armed, err SHALL set if an advance produces state 0 with the pre-advance count != 2^WIDTH-1, or produces state != 0 with the pre-advance count == 2^WIDTH-1. Once set, err SHALL hold until reset.
REQ-023 When LFSR_GEN_PERIOD_CHECK_EN is undefined, err SHALL be tied to 0 and no checker logic SHALL be synthesised.

Structure
REQ-024 Package lfsr_pkg SHALL hold the TAPS tap-mask table indexed by WIDTH for 3..16, plus the constants LFSR_MIN_WIDTH=3 and LFSR_MAX_WIDTH=16.
REQ-025 TAPS[8] SHALL equal 8'hB8 (x^8+x^6+x^5+x^4+1), and every table entry SHALL be a maximal-length polynomial.
REQ-026 The period checker SHALL be the sub-module lfsr_period_chk, instantiated only under LFSR_GEN_PERIOD_CHECK_EN.
REQ-027 A WIDTH outside 3..16 SHALL cause an elaboration-time error.

Verification
REQ-028 WIDTH=8, reset then en=1 -> out sequence 0x00, 0x01, 0x02, 0x04, 0x08, 0x11 on successive cycles.
REQ-029 WIDTH=8, en=1 for 256 cycles after reset -> every value seen exactly once, out==0 again at step 256, wrap high exactly once, err=0.
REQ-030 WIDTH=4, load=1 and en=1 same cycle with seed=4'h9 -> out=4'h9, count=0, wrap=0; en then toggled 1/0 -> state advances only on en=1 cycles.
REQ-031 WIDTH=8, rst=0 at step 100 -> next cycle out=0, count=0, wrap=0, err=0; following advance gives 0x01.
REQ-032 WIDTH=8 with macro, force the state to 0 at count=50 via load seed=0 then a forced-fault test hook -> err=1 and held until reset; with a nonzero seed load the checker is disarmed and err stays 0.
REQ-033 Sweep WIDTH=3..16, free-run 2^WIDTH advances -> period exactly 2^WIDTH, with no early zero.
